// File: rtl/alu_mdu.sv
// ============================================================================
// Module  : alu_mdu
// Purpose : Registered MIPS-style ALU with an iterative MULTU/DIVU unit,
//           HI/LO registers and a valid/ready handshake.
//           Optional macro ALU_SIGNED_SLT_EN enables signed SLT on op 1100.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             zero_flag,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             busy
);

    localparam int            c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [3:0] c_OP_AND   = 4'b0000;
    localparam logic [3:0] c_OP_OR    = 4'b0001;
    localparam logic [3:0] c_OP_ADD   = 4'b0010;
    localparam logic [3:0] c_OP_ANDN  = 4'b0100;
    localparam logic [3:0] c_OP_ORN   = 4'b0101;
    localparam logic [3:0] c_OP_SUB   = 4'b0110;
    localparam logic [3:0] c_OP_SLTU  = 4'b0111;
    localparam logic [3:0] c_OP_MULTU = 4'b1000;
    localparam logic [3:0] c_OP_DIVU  = 4'b1001;
    localparam logic [3:0] c_OP_MFHI  = 4'b1010;
    localparam logic [3:0] c_OP_MFLO  = 4'b1011;
    localparam logic [3:0] c_OP_SLT   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CW-1:0]      r_cnt;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_y;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_out_valid;
    logic                 r_div_zero;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_multi;
    logic [WIDTH-1:0]     w_alu_y;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH+1:0]     w_div_diff;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_step;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_cnt == c_LAST);
    assign w_multi  = (op == c_OP_MULTU) || (op == c_OP_DIVU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (w_accept && op == c_OP_MULTU)     w_state_next = S_MUL;
                else if (w_accept && op == c_OP_DIVU) w_state_next = S_DIV;
            end
            S_MUL, S_DIV: if (w_last) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_alu_y = '0;
        case (op)
            c_OP_AND:  w_alu_y = a & b;
            c_OP_OR:   w_alu_y = a | b;
            c_OP_ADD:  w_alu_y = a + b;
            c_OP_ANDN: w_alu_y = a & ~b;
            c_OP_ORN:  w_alu_y = a | ~b;
            c_OP_SUB:  w_alu_y = a - b;
            c_OP_SLTU: w_alu_y = WIDTH'(a < b);
            c_OP_MFHI: w_alu_y = r_hi;
            c_OP_MFLO: w_alu_y = r_lo;
`ifdef ALU_SIGNED_SLT_EN
            c_OP_SLT:  w_alu_y = WIDTH'($signed(a) < $signed(b));
`else
            c_OP_SLT:  w_alu_y = '0;
`endif
            default:   w_alu_y = '0;
        endcase
    end

    // Shift-add: add multiplicand into the upper half when LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    // With a zero divisor no borrow ever occurs, giving quotient all-ones and remainder a.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_next  = w_div_diff[WIDTH+1] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                             : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_step = (r_state == S_MUL) ? w_mul_next : w_div_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_out_valid <= 1'b0;
            r_div_zero  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_b   <= b;
                        r_acc <= {{WIDTH{1'b0}}, a};
                        if (!w_multi) begin
                            r_y         <= w_alu_y;
                            r_out_valid <= 1'b1;
                            r_div_zero  <= 1'b0;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + c_CW'(1);
                    if (w_last) begin
                        r_hi        <= w_step[2*WIDTH-1:WIDTH];
                        r_lo        <= w_step[WIDTH-1:0];
                        r_y         <= w_step[WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_div_zero  <= (r_state == S_DIV) && (r_b == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero_flag = (r_y == '0);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_zero  = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module  : tb_alu_mdu
// Purpose : Directed scoreboard bench for alu_mdu (WIDTH=32).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_mdu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] y;
    logic         zero_flag;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;
    logic         busy;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .y         (y),
        .zero_flag (zero_flag),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc    = 0;
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every out_valid pulse must match the oldest pending op.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_out_valid observed=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_y"},     64'(y),         64'(e.y));
                chk({e.tag, "_zf"},    64'(zero_flag), 64'(e.y == '0));
                chk({e.tag, "_hi"},    64'(hi),        64'(e.hi));
                chk({e.tag, "_lo"},    64'(lo),        64'(e.lo));
                chk({e.tag, "_dz"},    64'(div_zero),  64'(e.dz));
                chk({e.tag, "_cycle"}, 64'(cyc),       64'(e.cyc));
            end
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input string tag, output int waits);
        exp_t e;
        int   lat;
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        a        = xa;
        b        = xb;
        waits    = 0;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $error("FAIL %s_ready_timeout observed=0 expected=1", tag);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        e.dz     = 1'b0;
        case (o)
            4'b0000: e.y = xa & xb;
            4'b0001: e.y = xa | xb;
            4'b0010: e.y = xa + xb;
            4'b0100: e.y = xa & ~xb;
            4'b0101: e.y = xa | ~xb;
            4'b0110: e.y = xa - xb;
            4'b0111: e.y = (xa < xb) ? 1 : 0;
            4'b1000: begin
                {m_hi, m_lo} = 64'(xa) * 64'(xb);
                e.y = m_lo;
                lat = W + 1;
            end
            4'b1001: begin
                if (xb == 0) begin
                    m_lo = '1;
                    m_hi = xa;
                    e.dz = 1'b1;
                end else begin
                    m_lo = xa / xb;
                    m_hi = xa % xb;
                end
                e.y = m_lo;
                lat = W + 1;
            end
            4'b1010: e.y = m_hi;
            4'b1011: e.y = m_lo;
`ifdef ALU_SIGNED_SLT_EN
            4'b1100: e.y = ($signed(xa) < $signed(xb)) ? 1 : 0;
`else
            4'b1100: e.y = '0;
`endif
            default: e.y = '0;
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.cyc = cyc + lat - 1;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = '0;
        a        = '0;
        b        = '0;
        repeat (2) @(negedge clk);
        chk("rst_y",     64'(y),         64'd0);
        chk("rst_hi",    64'(hi),        64'd0);
        chk("rst_lo",    64'(lo),        64'd0);
        chk("rst_ov",    64'(out_valid), 64'd0);
        chk("rst_zf",    64'(zero_flag), 64'd1);
        chk("rst_ready", 64'(in_ready),  64'd1);
        chk("rst_busy",  64'(busy),      64'd0);
        rst = 1'b0;

        // Reset in the middle of a multiply aborts it silently.
        do_op(4'b1000, 32'h1234_5678, 32'h0000_9ABC, "mul_abort", w);
        repeat (9) @(posedge clk);
        chk("mid_mul_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_y",     64'(y),         64'd0);
        chk("arst_hi",    64'(hi),        64'd0);
        chk("arst_lo",    64'(lo),        64'd0);
        chk("arst_ov",    64'(out_valid), 64'd0);
        chk("arst_zf",    64'(zero_flag), 64'd1);
        chk("arst_ready", 64'(in_ready),  64'd1);
        chk("arst_busy",  64'(busy),      64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back single-cycle ops.
        do_op(4'b0010, 32'hFFFF_FFFF, 32'h1, "add_wrap", w);
        do_op(4'b0110, 32'd5, 32'd7, "sub_neg", w);
        do_op(4'b0000, 32'hF0F0_1234, 32'hFF00_00FF, "and", w);
        do_op(4'b0001, 32'hF0F0_1234, 32'h0F00_00FF, "or", w);
        do_op(4'b0011, 32'hDEAD_BEEF, 32'h1, "zero_op", w);
        do_op(4'b0100, 32'hFFFF_0000, 32'h0F0F_0F0F, "andn", w);
        do_op(4'b0101, 32'h0000_0001, 32'hFFFF_0000, "orn", w);
        do_op(4'b0111, 32'd3, 32'd9, "sltu_t", w);
        do_op(4'b1111, 32'hAAAA_AAAA, 32'h5, "undef", w);
        drain("alu");

        // Full-width multiply then read HI.
        do_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max", w);
        do_op(4'b1010, 32'h0, 32'h0, "mfhi", w);
        do_op(4'b1011, 32'h0, 32'h0, "mflo", w);
        drain("mul");

        do_op(4'b1001, 32'd100, 32'd7, "div", w);
        do_op(4'b1001, 32'd5, 32'd0, "div0", w);
        do_op(4'b0001, 32'h0, 32'h0, "dz_clear", w);
        do_op(4'b1000, 32'h0001_2345, 32'h0000_6789, "mul_mid", w);
        drain("div");

        // ADD held during a multiply: accepted on the completion cycle.
        do_op(4'b1000, 32'hDEAD_BEEF, 32'h0000_1000, "mul_hold", w);
        do_op(4'b0010, 32'd10, 32'd20, "add_held", w);
        chk("held_wait_cycles", 64'(w), 64'(W));
        drain("hold");

        do_op(4'b0111, 32'h8000_0000, 32'h1, "sltu_msb", w);
        do_op(4'b1100, 32'h8000_0000, 32'h1, "slt_signed", w);
        drain("slt");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
